// File: rtl/tcm_pkg.sv
// Shared TCM definitions: bus widths, default depth and response owner encoding.
package tcm_pkg;

   localparam int unsigned TCM_AW    = 14;
   localparam int unsigned TCM_DW    = 32;
   localparam int unsigned TCM_BW    = 4;
   localparam int unsigned TCM_DEPTH = 4096;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_e;

endpackage

// File: rtl/tcm_port_arb_if.sv
// Requester A/B and RAM-port signals of the TCM port arbiter.
interface tcm_port_arb_if;
   import tcm_pkg::*;

   logic              a_valid_i;
   logic [TCM_AW-1:0] a_addr_i;
   logic [TCM_DW-1:0] a_data_i;
   logic [TCM_BW-1:0] a_wr_i;
   logic              a_accept_o;
   logic              a_ack_o;
   logic [TCM_DW-1:0] a_data_o;
   logic              a_err_o;

   logic              b_valid_i;
   logic [TCM_AW-1:0] b_addr_i;
   logic [TCM_DW-1:0] b_data_i;
   logic [TCM_BW-1:0] b_wr_i;
   logic              b_accept_o;
   logic              b_ack_o;
   logic [TCM_DW-1:0] b_data_o;
   logic              b_err_o;

   logic [TCM_AW-1:0] ram_addr_o;
   logic [TCM_DW-1:0] ram_data_o;
   logic [TCM_BW-1:0] ram_wr_o;
   logic [TCM_DW-1:0] ram_data_i;

   // Arbiter side.
   modport slave (
      input  a_valid_i, a_addr_i, a_data_i, a_wr_i,
      output a_accept_o, a_ack_o, a_data_o, a_err_o,
      input  b_valid_i, b_addr_i, b_data_i, b_wr_i,
      output b_accept_o, b_ack_o, b_data_o, b_err_o,
      output ram_addr_o, ram_data_o, ram_wr_o,
      input  ram_data_i
   );

   // Requesters and RAM side.
   modport master (
      output a_valid_i, a_addr_i, a_data_i, a_wr_i,
      input  a_accept_o, a_ack_o, a_data_o, a_err_o,
      output b_valid_i, b_addr_i, b_data_i, b_wr_i,
      input  b_accept_o, b_ack_o, b_data_o, b_err_o,
      input  ram_addr_o, ram_data_o, ram_wr_o,
      output ram_data_i
   );

endinterface

// File: rtl/tcm_arb_pri.sv
// A-priority grant with a bounded wait counter that forces B ahead after B_MAX_WAIT refusals.
module tcm_arb_pri #(
   parameter int unsigned B_MAX_WAIT = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       a_valid_i,
   input  logic       b_valid_i,
   output logic [1:0] gnt_o     // [0] = A, [1] = B
);

   localparam logic [7:0] MaxWait = 8'(B_MAX_WAIT);

   logic [7:0] wait_q, wait_d;
   logic       b_force;

   always_comb begin
      gnt_o   = 2'b00;
      wait_d  = wait_q;
      b_force = b_valid_i && (wait_q >= MaxWait);

      if (b_valid_i && (b_force || !a_valid_i)) begin
         gnt_o[1] = 1'b1;
      end else if (a_valid_i) begin
         gnt_o[0] = 1'b1;
      end

      // B is refused only when it is valid and A took the port.
      if (gnt_o[1]) begin
         wait_d = 8'd0;
      end else if (b_valid_i && (wait_q < MaxWait)) begin
         wait_d = wait_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wait_q <= 8'd0;
      end else begin
         wait_q <= wait_d;
      end
   end

endmodule

// File: rtl/tcm_port_arb.sv
// Shares one TCM RAM port between requesters A and B; range-checks and routes read responses.
module tcm_port_arb
   import tcm_pkg::*;
#(
   parameter int unsigned DEPTH      = TCM_DEPTH,
   parameter int unsigned B_MAX_WAIT = 4
) (
   input logic           clk_i,
   input logic           rst_n_i,
   tcm_port_arb_if.slave bus
);

   logic [1:0]        gnt;
   logic              acc_a, acc_b, acc;
   owner_e            sel_owner;
   logic [TCM_AW-1:0] sel_addr;
   logic [TCM_DW-1:0] sel_data;
   logic [TCM_BW-1:0] sel_wr;
   logic              sel_oor;

   logic              rsp_valid_q;
   owner_e            rsp_owner_q;
   logic              rsp_err_q;
   logic [TCM_DW-1:0] rsp_data;
   logic              a_own, b_own;

   tcm_arb_pri #(
      .B_MAX_WAIT (B_MAX_WAIT)
   ) u_arb (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .a_valid_i (bus.a_valid_i),
      .b_valid_i (bus.b_valid_i),
      .gnt_o     (gnt)
   );

   // Nothing may be accepted or driven to the RAM while reset is held.
   assign acc_a = gnt[0] & rst_n_i;
   assign acc_b = gnt[1] & rst_n_i;
   assign acc   = acc_a | acc_b;

   assign bus.a_accept_o = acc_a;
   assign bus.b_accept_o = acc_b;

   always_comb begin
      sel_owner = OWN_A;
      sel_addr  = '0;
      sel_data  = '0;
      sel_wr    = '0;
      if (acc_b) begin
         sel_owner = OWN_B;
         sel_addr  = bus.b_addr_i;
         sel_data  = bus.b_data_i;
         sel_wr    = bus.b_wr_i;
      end else if (acc_a) begin
         sel_addr  = bus.a_addr_i;
         sel_data  = bus.a_data_i;
         sel_wr    = bus.a_wr_i;
      end
      sel_oor = acc && ({18'd0, sel_addr} >= DEPTH);
   end

   // Out-of-range requests keep their address but never write, so they cannot alias.
   assign bus.ram_addr_o = sel_addr;
   assign bus.ram_data_o = sel_data;
   assign bus.ram_wr_o   = sel_oor ? '0 : sel_wr;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= OWN_A;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= acc;
         rsp_owner_q <= sel_owner;
         rsp_err_q   <= sel_oor;
      end
   end

   always_comb begin
      rsp_data = rsp_err_q ? '0 : bus.ram_data_i;
      a_own    = rsp_valid_q && (rsp_owner_q == OWN_A);
      b_own    = rsp_valid_q && (rsp_owner_q == OWN_B);
   end

   assign bus.a_ack_o  = a_own;
   assign bus.a_err_o  = a_own & rsp_err_q;
   assign bus.a_data_o = a_own ? rsp_data : '0;
   assign bus.b_ack_o  = b_own;
   assign bus.b_err_o  = b_own & rsp_err_q;
   assign bus.b_data_o = b_own ? rsp_data : '0;

endmodule

// File: tb/tb_tcm_port_arb.sv
// Scoreboard bench for tcm_port_arb: a behavioural grant/memory model predicts accepts and acks.
module tb_tcm_port_arb;
   import tcm_pkg::*;

   localparam int unsigned Depth   = 4096;
   localparam int          MaxWait = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tcm_port_arb_if bus ();

   tcm_port_arb #(
      .DEPTH      (Depth),
      .B_MAX_WAIT (MaxWait)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   typedef struct {
      int unsigned due;
      logic        owner;
      logic        is_wr;
      logic        err;
      logic [31:0] data;
   } rsp_t;

   rsp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   int          model_wait = 0;

   logic [31:0] ram [4096];
   bit          ram_wr_seen [4096];
   logic [31:0] ref_mem [4096];
   bit          ref_wr_seen [4096];
   logic [31:0] ram_rdata;

   function automatic logic [31:0] init_word(input int a);
      if (a == 16) return 32'h1234_5678;
      if (a == 32) return 32'h1111_1111;
      return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0103);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // RAM port model: registered read, old data on read-during-write.
   always @(posedge clk) begin
      ram_rdata <= ram_wr_seen[bus.ram_addr_o[11:0]] ? ram[bus.ram_addr_o[11:0]]
                                                      : init_word(int'(bus.ram_addr_o[11:0]));
      if (bus.ram_wr_o != 4'd0) begin
         ram[bus.ram_addr_o[11:0]] <= merge(ram_wr_seen[bus.ram_addr_o[11:0]] ?
                                            ram[bus.ram_addr_o[11:0]] :
                                            init_word(int'(bus.ram_addr_o[11:0])),
                                            bus.ram_data_o, bus.ram_wr_o);
         ram_wr_seen[bus.ram_addr_o[11:0]] <= 1'b1;
      end
   end
   assign bus.ram_data_i = ram_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Grant/wait model and request-side checks; pushes expected responses.
   initial begin : acc_chk
      logic        ea, eb, oor;
      logic [13:0] sa;
      logic [31:0] sd, old;
      logic [3:0]  sw;
      rsp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_a_accept", bus.a_accept_o, 0);
            check("rst_b_accept", bus.b_accept_o, 0);
            check("rst_ram_wr", bus.ram_wr_o, 0);
            check("rst_ram_addr", bus.ram_addr_o, 0);
            check("rst_ram_data", bus.ram_data_o, 0);
            check("rst_wait", dut.u_arb.wait_q, 0);
            model_wait = 0;
         end else begin
            eb = bus.b_valid_i && (model_wait >= MaxWait || !bus.a_valid_i);
            ea = bus.a_valid_i && !eb;
            check("wait_q", dut.u_arb.wait_q, 32'(model_wait));
            check("a_accept", bus.a_accept_o, ea);
            check("b_accept", bus.b_accept_o, eb);
            if (ea || eb) begin
               sa  = eb ? bus.b_addr_i : bus.a_addr_i;
               sd  = eb ? bus.b_data_i : bus.a_data_i;
               sw  = eb ? bus.b_wr_i   : bus.a_wr_i;
               oor = int'(sa) >= int'(Depth);
               old = ref_wr_seen[sa[11:0]] ? ref_mem[sa[11:0]] : init_word(int'(sa[11:0]));
               e.due   = cyc + 1;
               e.owner = eb;
               e.is_wr = (sw != 4'd0);
               e.err   = oor;
               e.data  = oor ? 32'd0 : old;
               if (!oor && sw != 4'd0) begin
                  ref_mem[sa[11:0]]     = merge(old, sd, sw);
                  ref_wr_seen[sa[11:0]] = 1'b1;
               end
               exp_q.push_back(e);
               check("ram_addr", bus.ram_addr_o, sa);
               check("ram_data", bus.ram_data_o, sd);
               check("ram_wr", bus.ram_wr_o, oor ? 4'd0 : sw);
            end else begin
               check("idle_ram_wr", bus.ram_wr_o, 0);
               check("idle_ram_addr", bus.ram_addr_o, 0);
               check("idle_ram_data", bus.ram_data_o, 0);
            end
            if (eb) model_wait = 0;
            else if (bus.b_valid_i && model_wait < MaxWait) model_wait++;
         end
      end
   end

   // Response monitor: pops the scoreboard whenever a response is due.
   initial begin : mon
      rsp_t e;
      logic has, oa, ob;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_a_ack", bus.a_ack_o, 0);
            check("rst_b_ack", bus.b_ack_o, 0);
            check("rst_a_err", bus.a_err_o, 0);
            check("rst_b_err", bus.b_err_o, 0);
            exp_q.delete();
         end else begin
            has = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            if (has) e = exp_q.pop_front();
            oa = has && !e.owner;
            ob = has && e.owner;
            check("a_ack", bus.a_ack_o, oa);
            check("b_ack", bus.b_ack_o, ob);
            check("a_err", bus.a_err_o, oa && e.err);
            check("b_err", bus.b_err_o, ob && e.err);
            if (!(oa && e.is_wr)) check("a_data", bus.a_data_o, oa ? e.data : 32'd0);
            if (!(ob && e.is_wr)) check("b_data", bus.b_data_o, ob ? e.data : 32'd0);
         end
      end
   end

   task automatic set_req(input bit s, input logic v, input logic [13:0] a,
                          input logic [31:0] d, input logic [3:0] w);
      if (!s) begin
         bus.a_valid_i = v; bus.a_addr_i = a; bus.a_data_i = d; bus.a_wr_i = w;
      end else begin
         bus.b_valid_i = v; bus.b_addr_i = a; bus.b_data_i = d; bus.b_wr_i = w;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds one request until accepted; entered and left 1 time unit after a rising edge.
   task automatic drive(input bit s, input logic [13:0] a, input logic [31:0] d,
                        input logic [3:0] w);
      bit got;
      got = 1'b0;
      set_req(s, 1'b1, a, d, w);
      for (int k = 0; k < 32 && !got; k++) begin
         @(negedge clk);
         got = s ? bus.b_accept_o : bus.a_accept_o;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL accept_timeout: requester %0d addr %h got no accept, required one", s, a);
      end
      @(posedge clk);
      #1;
      set_req(s, 1'b0, 14'd0, 32'd0, 4'd0);
   endtask

   function automatic logic [13:0] rand_addr();
      if ($urandom_range(15) == 0) return 14'($urandom_range(16383, 4096));
      return 14'($urandom_range(63));
   endfunction

   function automatic logic [3:0] rand_wr();
      if ($urandom_range(1) == 0) return 4'd0;
      return 4'($urandom_range(15, 1));
   endfunction

   task automatic rand_req(input bit s, input int n, input int pct, input int drop_pct);
      bit busy, taken;
      busy  = 1'b0;
      taken = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!busy || taken) begin
            if (int'($urandom_range(99)) < pct) begin
               set_req(s, 1'b1, rand_addr(), $urandom(), rand_wr());
               busy = 1'b1;
            end else begin
               set_req(s, 1'b0, 14'd0, 32'd0, 4'd0);
               busy = 1'b0;
            end
         end else if (int'($urandom_range(99)) < drop_pct) begin
            set_req(s, 1'b0, 14'd0, 32'd0, 4'd0);
            busy = 1'b0;
         end
         @(negedge clk);
         taken = s ? bus.b_accept_o : bus.a_accept_o;
         @(posedge clk);
         #1;
      end
      set_req(s, 1'b0, 14'd0, 32'd0, 4'd0);
   endtask

   initial begin
      set_req(1'b0, 1'b0, 14'd0, 32'd0, 4'd0);
      set_req(1'b1, 1'b0, 14'd0, 32'd0, 4'd0);
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;

      drive(1'b0, 14'h010, 32'd0, 4'd0);
      for (int i = 0; i < 4; i++) drive(1'b0, 14'(i), 32'd0, 4'd0);
      idle(1);

      fork
         rand_req(1'b0, 12, 100, 0);
         rand_req(1'b1, 12, 100, 0);
      join
      idle(2);

      drive(1'b1, 14'h020, 32'hAABB_CCDD, 4'b0010);
      drive(1'b1, 14'h020, 32'd0, 4'd0);

      drive(1'b0, 14'h1000, 32'hDEAD_BEEF, 4'hF);
      drive(1'b0, 14'h000, 32'd0, 4'd0);
      idle(2);

      drive(1'b0, 14'h005, 32'd0, 4'd0);
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(3);

      fork
         rand_req(1'b0, 2000, 60, 5);
         rand_req(1'b1, 2000, 50, 5);
      join
      idle(4);

      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
